// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath constants and the serial subtractor state type
package cpu_pkg;
  localparam int DATA_W = 24;
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} zbr_state_t;
endpackage

// File: rtl/zbritesi_bit.sv
// zbritesi_bit: combinational full-subtractor cell, dual of the full-adder cell
module zbritesi_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/zbritesi_serial.sv
// zbritesi_serial: bit-serial W-bit subtractor (A - B - borrow_in), LSB first, start/done handshake
// Define ZBRITESI_FLAGS_EN to add the registered zero/ovf flag ports.
module zbritesi_serial
  import cpu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
`ifdef ZBRITESI_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);
  localparam int CW = W == DATA_W ? CNT_W : $clog2(W);
  zbr_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] sa, sb, diff_nxt;
  logic br, d, bo, last, load;
  zbritesi_bit u_bit (.a(sa[0]), .b(sb[0]), .bin(br), .diff(d), .bout(bo));
  assign last = cnt == CW'(W - 1);
  assign load = start && state != SHIFT;
  assign diff_nxt = {d, diff[W-1:1]};
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      br <= 1'b0;
      sa <= '0;
      sb <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      br <= borrow_in;
      sa <= a;
      sb <= b;
    end else if (state == SHIFT) begin
      cnt <= last ? cnt : cnt + 1'b1;
      br <= bo;
      sa <= sa >> 1;
      sb <= sb >> 1;
      diff <= diff_nxt;
      if (last) borrow_out <= bo;
    end
`ifdef ZBRITESI_FLAGS_EN
  // operand MSBs are shifted out of sa/sb, so keep them for the overflow flag
  logic am, bm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      am <= 1'b0;
      bm <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      am <= a[W-1];
      bm <= b[W-1];
    end else if (state == SHIFT && last) begin
      zero <= diff_nxt == '0;
      ovf <= (am ^ bm) & (d ^ am);
    end
`endif
endmodule

// File: tb/tb_zbritesi_serial.sv
// tb_zbritesi_serial: directed vectors plus a cycle-timestamp model of the serial subtractor
module tb_zbritesi_serial;
  localparam int W = 24;
  logic clk = 0, rst_n = 0, start = 0, borrow_in = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef ZBRITESI_FLAGS_EN
  logic zero, ovf;
`endif
  int pass_cnt = 0, total = 0;
  always #5 clk = ~clk;
  zbritesi_serial #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef ZBRITESI_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask
  // model: an accepted start at edge index acc yields busy after edges acc..acc+W-1 and done after acc+W
  int cyc = 0, acc = 0;
  bit active = 0;
  logic [W:0] full;
  logic [W-1:0] p_diff = '0, m_diff = '0;
  logic p_bo = 0, m_bo = 0, p_ovf = 0, m_ovf = 0;
  always @(posedge clk) begin
    if (rst_n && start && !(active && cyc - acc < W)) begin
      full = {1'b0, a} - {1'b0, b} - (W + 1)'(borrow_in);
      p_diff = full[W-1:0];
      p_bo = full[W];
      p_ovf = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
      active = 1;
      acc = cyc + 1;
    end
    cyc++;
  end
  always @(negedge rst_n) begin
    active = 0;
    m_diff = '0;
    m_bo = 0;
    m_ovf = 0;
  end
  always @(negedge clk) begin
    int k;
    bit eb, ed;
    k = cyc - acc;
    eb = active && k < W;
    ed = active && k == W;
    if (ed) begin
      m_diff = p_diff;
      m_bo = p_bo;
      m_ovf = p_ovf;
    end
    chk("busy", busy, eb);
    chk("done", done, ed);
    if (!eb) begin
      chk("diff", diff, m_diff);
      chk("borrow_out", borrow_out, m_bo);
`ifdef ZBRITESI_FLAGS_EN
      chk("zero", zero, m_diff == '0);
      chk("ovf", ovf, m_ovf);
`endif
    end
  end
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbi,
                    input int poke, output int lat);
    a = ta;
    b = tb;
    borrow_in = tbi;
    start = 1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = poke != 0 && n == poke;
      if (start) begin
        a = ~ta;
        b = 24'h000005;
        borrow_in = ~tbi;
      end
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    start = 0;
  endtask
  task automatic lit(input string name, input logic [W-1:0] ed, input logic eb, input int lat);
    chk({name, "_latency"}, lat, 24);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_borrow"}, borrow_out, eb);
  endtask
  initial begin
    int lat, t1, t2;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    rst_n = 1;
    @(negedge clk);
    op(24'h000005, 24'h000003, 0, 0, lat);
    lit("5m3", 24'h000002, 0, lat);
`ifdef ZBRITESI_FLAGS_EN
    chk("5m3_zero", zero, 0);
    chk("5m3_ovf", ovf, 0);
`endif
    op(24'h000003, 24'h000005, 0, 0, lat);
    lit("3m5", 24'hFFFFFE, 1, lat);
    op(24'h800000, 24'h000001, 0, 0, lat);
    lit("ovf", 24'h7FFFFF, 0, lat);
`ifdef ZBRITESI_FLAGS_EN
    chk("ovf_flag", ovf, 1);
`endif
    op(24'h123456, 24'h123456, 0, 0, lat);
    lit("eq", 24'h000000, 0, lat);
`ifdef ZBRITESI_FLAGS_EN
    chk("eq_zero", zero, 1);
`endif
    op(24'h00000A, 24'h000004, 0, 10, lat);
    lit("ignored_start", 24'h000006, 0, lat);
    a = 24'hABCDEF;
    b = 24'h012345;
    start = 1;
    repeat (12) begin
      @(negedge clk);
      start = 0;
    end
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_diff", diff, 0);
    chk("async_rst_borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    op(24'h000007, 24'h000007, 1, 0, lat);
    lit("7m7b1", 24'hFFFFFF, 1, lat);
    a = 24'h000100;
    b = 24'h000001;
    borrow_in = 0;
    start = 1;
    t1 = -1;
    t2 = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (t1 >= 0 && n == t1 + 1) start = 0;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          chk("b2b_first_diff", diff, 24'h0000FF);
          a = 24'h000020;
          b = 24'h000030;
        end else begin
          t2 = n;
          break;
        end
      end
    end
    start = 0;
    chk("b2b_spacing", t2 - t1, 25);
    chk("b2b_second_diff", diff, 24'hFFFFF0);
    chk("b2b_second_borrow", borrow_out, 1);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/zbritesi_serial.md
# zbritesi_serial

Bit-serial 24-bit subtractor for the CPU datapath. It computes A − B − borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It trades latency for area next to the ripple full-adder chain. The ALU launches it with a start/done handshake and reads the difference and status flags when `done` pulses.

## Interface
- `W`, default 24: operand and result width in bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  launch request; sampled only while not busy.
- `a`  input  W  minuend; captured on the accepted start.
- `b`  input  W  subtrahend; captured on the accepted start.
- `borrow_in`  input  1  initial borrow; captured on the accepted start.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  single-cycle pulse when the result becomes valid.
- `diff`  output  W  the difference A − B − borrow_in, modulo 2^W.
- `borrow_out`  output  1  final borrow; 1 when the unsigned result A < B + borrow_in.
- `zero`  output  1  diff == 0 (only when ZBRITESI_FLAGS_EN is defined).
- `ovf`  output  1  signed overflow (only when ZBRITESI_FLAGS_EN is defined).

## Operation
- States:
  - IDLE: waiting for `start`.
  - SHIFT: processing one bit per clock.
  - DONE: result presented, `done` high.
- Transitions:
  - IDLE →SHIFT on `start`. At the same time, `a`, `b` and `borrow_in` are loaded into the shift registers and the borrow flop, and the bit counter is cleared.
  - SHIFT → DONE when the counter reaches W−1 and that bit is processed.
  - DONE → SHIFT if `start` is high; otherwise DONE → IDLE.
- Per SHIFT cycle:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~a0 & br) | (b0 & br).
  - The A and B shift registers shift right.
  - d enters the MSB of the diff register, which also shifts right.
- After W shifts, `diff` holds the full result in natural bit order and `borrow_out` equals the final br.
- `start` while `busy` is ignored; operands are not re-captured.
- `diff` and the flags are held stable from `done` until the next accepted start. During SHIFT, `diff` shows partial contents and is not valid.
- `ovf` = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]). It uses the captured operand MSBs, so these must be kept in dedicated flops.
- Reset is asynchronous at any time, including mid-operation. It forces IDLE; `busy`, `done`, `diff`, `borrow_out`, `zero`, `ovf`, the counter and the borrow flop all go to 0. No partial result survives reset.

## Timing
- Start accepted at edge 0. Bits are processed on edges 1..W, and `busy` is high from edge 0 through edge W.
- `done` is high for exactly the one cycle following edge W, together with valid `diff` and flags. Latency from start to result is W cycles (24 at the default).
- Throughput: the next start can be accepted during the DONE cycle, giving back-to-back operation every W+1 cycles (every 25 cycles at the default).
- The counter is ceil(log2(W)) bits wide and counts 0..W−1 with no wrap-around beyond that range.

## Configuration
- `ZBRITESI_FLAGS_EN` defined: the `zero` and `ovf` ports exist, are registered, and are updated on the edge that enters DONE.
- Macro undefined: these ports and their flops are removed entirely. `borrow_out` is always present.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_W = 24`.
  - The state enum `zbr_state_t` {IDLE, SHIFT, DONE}.
  - The counter width constant.
- One sub-module, `zbritesi_bit`. It is a combinational full-subtractor cell (inputs A, B, BIN; outputs DIFF, BOUT) and is the dual of the existing full-adder cell. It is instantiated once and fed by the borrow flop.

## Test plan
- 5 − 3, borrow_in=0 → diff=0x000002, borrow_out=0, zero=0, ovf=0; done pulses exactly 24 cycles after start.
- 3 − 5 → diff=0xFFFFFE, borrow_out=1, ovf=0.
- 0x800000 − 0x000001 → diff=0x7FFFFF, ovf=1, borrow_out=0. Also 0x123456 − 0x123456 → diff=0, zero=1.
- Start pulsed again at cycle 10 with different operands → ignored; the original result is produced, and `busy` stays high without interruption.
- `rst_n` low at cycle 12 of an operation → all outputs go to 0 immediately and the block returns to IDLE. A subsequent 7 − 7 with borrow_in=1 gives diff=0xFFFFFF, borrow_out=1.
- Start held high through DONE → the second operation begins with no idle cycle and its done pulse comes 25 cycles after the first.
